mem_bridge_sequencer: RTL and testbench

MEM_BRIDGE_SEQUENCER -- requirements
Module: mem_bridge_sequencer

---
 rtl/mem_bridge_sequencer.sv | 143 ++++++++++++++
 tb/tb_mem_bridge_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge_sequencer.sv
// Sequences one pipeline request into SETUP/STROBE/HOLD timing on an async 8-bit memory bus.
// Optional ROM write blocking: define MEM_BRIDGE_ROM_WRITE_BLOCK_EN.
module mem_bridge_sequencer #(
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        WR_ROM_ERR,
  output logic [15:0] Addr,
  inout  wire  [7:0]  MEMDATA,
  output logic        MemBridge_Load,
  output logic        MemBridge_Direction
);

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bridgeState_t;

  bridgeState_t state_r, nextState_s;
  logic [3:0]  waitCnt_r, nextWaitCnt_s;
  logic        isWrite_r, writeNext_s;
  logic [15:0] addr_r;
  logic [7:0]  wdata_r, rdata_r;
  logic        handshake_s, capture_s, loadAllowed_s;
  logic        loadNext_s, dirNext_s, driveNext_s, rspValidNext_s, romErrNext_s;
  logic        load_r, dir_r, drive_r, rspValid_r, romErr_r;

  assign REQ_READY   = (state_r == IDLE) && !RESET;
  assign handshake_s = REQ_VALID && REQ_READY;
  // Outputs are registered, so they are decoded from the state being entered.
  assign writeNext_s = handshake_s ? REQ_WRITE : isWrite_r;

`ifdef MEM_BRIDGE_ROM_WRITE_BLOCK_EN
  logic [15:0] addrNext_s;
  assign addrNext_s    = handshake_s ? REQ_ADDR : addr_r;
  assign loadAllowed_s = addrNext_s[15];
  assign romErrNext_s  = writeNext_s && !addrNext_s[15] && (nextState_s == HOLD);
`else
  assign loadAllowed_s = 1'b1;
  assign romErrNext_s  = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state and wait-counter decode
  always_comb begin
    nextState_s   = state_r;
    nextWaitCnt_s = waitCnt_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) begin
          nextState_s = SETUP;
        end else begin
          nextState_s = IDLE;
        end
      end
      SETUP: begin
        nextState_s   = STROBE;
        nextWaitCnt_s = 4'd0;
      end
      STROBE: begin
        if (waitCnt_r == LAST_WAIT) begin
          nextState_s   = HOLD;
          nextWaitCnt_s = 4'd0;
        end else begin
          nextState_s   = STROBE;
          nextWaitCnt_s = waitCnt_r + 4'd1;
        end
      end
      HOLD: begin
        nextState_s = IDLE;
      end
      default: begin
        nextState_s   = IDLE;
        nextWaitCnt_s = 4'd0;
      end
    endcase
  end

  // Bus control decode; read direction and write strobe are disjoint by construction
  always_comb begin
    dirNext_s      = !(!writeNext_s && ((nextState_s == SETUP) || (nextState_s == STROBE)));
    loadNext_s     = !(writeNext_s && (nextState_s == STROBE) && loadAllowed_s);
    driveNext_s    = writeNext_s && (nextState_s != IDLE);
    rspValidNext_s = !writeNext_s && (nextState_s == HOLD);
    capture_s      = !isWrite_r && (state_r == STROBE) && (nextState_s == HOLD);
  end

  // Request latch, read capture and registered bus outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      waitCnt_r  <= 4'd0;
      isWrite_r  <= 1'b0;
      addr_r     <= 16'h0000;
      wdata_r    <= 8'h00;
      rdata_r    <= 8'h00;
      load_r     <= 1'b1;
      dir_r      <= 1'b1;
      drive_r    <= 1'b0;
      rspValid_r <= 1'b0;
      romErr_r   <= 1'b0;
    end else begin
      waitCnt_r  <= nextWaitCnt_s;
      isWrite_r  <= writeNext_s;
      addr_r     <= handshake_s ? REQ_ADDR : addr_r;
      wdata_r    <= handshake_s ? REQ_WDATA : wdata_r;
      rdata_r    <= capture_s ? MEMDATA : rdata_r;
      load_r     <= loadNext_s;
      dir_r      <= dirNext_s;
      drive_r    <= driveNext_s;
      rspValid_r <= rspValidNext_s;
      romErr_r   <= romErrNext_s;
    end
  end

  assign MEMDATA             = drive_r ? wdata_r : 8'hzz;
  assign Addr                = addr_r;
  assign RSP_RDATA           = rdata_r;
  assign RSP_VALID           = rspValid_r;
  assign WR_ROM_ERR          = romErr_r;
  assign MemBridge_Load      = load_r;
  assign MemBridge_Direction = dir_r;

endmodule

// File: tb/tb_mem_bridge_sequencer.sv
// Randomized bench for mem_bridge_sequencer: cycle-timeline reference model plus a RAM/ROM bus model.
module tb_mem_bridge_sequencer;

  localparam int WS = 3;
`ifdef MEM_BRIDGE_ROM_WRITE_BLOCK_EN
  localparam bit ROM_BLOCK = 1'b1;
`else
  localparam bit ROM_BLOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, reqValid, reqWrite, reqReady, rspValid, wrRomErr, memLoad, memDir;
  logic [15:0] reqAddr, addr;
  logic [7:0]  reqWdata, rspRdata;
  wire  [7:0]  memData;

  always #5 clk = ~clk;

  mem_bridge_sequencer #(.WAIT_STATES(WS)) dut (
    .CLK(clk), .RESET(reset), .REQ_VALID(reqValid), .REQ_READY(reqReady),
    .REQ_WRITE(reqWrite), .REQ_ADDR(reqAddr), .REQ_WDATA(reqWdata),
    .RSP_VALID(rspValid), .RSP_RDATA(rspRdata), .WR_ROM_ERR(wrRomErr),
    .Addr(addr), .MEMDATA(memData), .MemBridge_Load(memLoad),
    .MemBridge_Direction(memDir)
  );

  // Power-up contents of the two memory halves
  function automatic logic [7:0] baseRam(input logic [14:0] i);
    if (i == 15'h0000) return 8'h5A;
    else if (i == 15'h7FFF) return 8'h22;
    else return 8'(i * 15'd7 + 15'd3);
  endfunction

  function automatic logic [7:0] baseRom(input logic [14:0] i);
    if (i == 15'h7FFF) return 8'h11;
    else return 8'(i) ^ 8'hA5;
  endfunction

  // Memory model: upper half RAM (written while Load low), lower half ROM
  logic [7:0] ramMem   [0:32767];
  bit         ramValid [0:32767];
  always @(posedge clk) begin
    if (!memLoad && addr[15]) begin
      ramMem[addr[14:0]]   <= memData;
      ramValid[addr[14:0]] <= 1'b1;
    end
  end
  assign memData = memDir ? 8'hzz :
                   (addr[15] ? (ramValid[addr[14:0]] ? ramMem[addr[14:0]] : baseRam(addr[14:0]))
                             : baseRom(addr[14:0]));

  // Reference model state
  logic [7:0]  expRam [logic [14:0]];
  int          phase;
  logic        txW, hsSeen;
  logic [15:0] txA, expAddr;
  logic [7:0]  txD, expRdata;
  int          passCount = 0;
  int          totalCount = 0;
  logic [15:0] pool [8] = '{16'h0000, 16'h1000, 16'h7FFF, 16'h8000,
                            16'h8001, 16'h9234, 16'hFFFF, 16'hC0DE};

  function automatic logic [7:0] expRead(input logic [15:0] a);
    if (!a[15]) return baseRom(a[14:0]);
    else if (expRam.exists(a[14:0])) return expRam[a[14:0]];
    else return baseRam(a[14:0]);
  endfunction

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    totalCount++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (phase %0d, t=%0t)", tag, got, exp, phase, $time);
    else passCount++;
  endtask

  // One clock cycle: drive inputs, check outputs against the timeline, advance the model
  task automatic stepCycle(input logic v, input logic w, input logic [15:0] a,
                           input logic [7:0] d, input logic rst);
    logic loadAct, expDir, expRspV, expErr;
    @(negedge clk);
    reqValid = v; reqWrite = w; reqAddr = a; reqWdata = d; reset = rst;
    #1;
    loadAct = txW && phase >= 2 && phase <= WS + 1 && (txA[15] || !ROM_BLOCK);
    expDir  = !(!txW && phase >= 1 && phase <= WS + 1);
    expRspV = !txW && phase == WS + 2;
    expErr  = ROM_BLOCK && txW && !txA[15] && phase == WS + 2;
    checkVal("ready", 16'(reqReady), 16'(phase == 0 && !rst));
    checkVal("load", 16'(memLoad), 16'(!loadAct));
    checkVal("dir", 16'(memDir), 16'(expDir));
    checkVal("rspValid", 16'(rspValid), 16'(expRspV));
    checkVal("romErr", 16'(wrRomErr), 16'(expErr));
    checkVal("addr", addr, expAddr);
    checkVal("rdata", 16'(rspRdata), 16'(expRdata));
    checkVal("noClash", 16'(!memLoad && !memDir), 16'd0);
    if (txW && phase >= 1) checkVal("busData", 16'(memData), 16'(txD));

    hsSeen = 1'b0;
    if (loadAct && txA[15]) expRam[txA[14:0]] = txD;
    if (rst) begin
      phase = 0; expAddr = 16'h0000; expRdata = 8'h00;
    end else if (phase == 0) begin
      if (v) begin
        phase = 1; txW = w; txA = a; txD = d; expAddr = a; hsSeen = 1'b1;
      end
    end else if (phase == WS + 2) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == WS + 2 && !txW) expRdata = expRead(txA);
    end
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    hsSeen = 1'b0;
    while (!hsSeen && n < 40) begin
      stepCycle(1'b1, w, a, d, 1'b0);
      n++;
    end
    if (!hsSeen) checkVal("hsTimeout", 16'd0, 16'd1);
  endtask

  task automatic drain(input bit noisyValid);
    int n = 0;
    while (phase != 0 && n < 40) begin
      stepCycle(noisyValid ? 1'($urandom) : 1'b0, 1'($urandom), 16'($urandom), 8'($urandom), 1'b0);
      n++;
    end
    if (phase != 0) checkVal("drainTimeout", 16'd0, 16'd1);
  endtask

  task automatic resetAtPhase(input int target);
    int n = 0;
    while (phase != target && n < 20) begin
      stepCycle(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 1'b0);
      n++;
    end
    stepCycle(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 1'b1);
  endtask

  initial begin
    reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 16'h0000; reqWdata = 8'h00;
    repeat (2) @(posedge clk);
    phase = 0; txW = 1'b0; txA = 16'h0000; txD = 8'h00; expAddr = 16'h0000; expRdata = 8'h00;
    stepCycle(1'b1, 1'b0, 16'h8000, 8'h00, 1'b1);
    stepCycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

    // Directed: read, write then read back, top-of-map read, lower-half write
    issue(1'b0, 16'h8000, 8'h00); drain(1'b0);
    checkVal("rd8000", 16'(rspRdata), 16'h005A);
    issue(1'b1, 16'h9234, 8'hC3); drain(1'b0);
    issue(1'b0, 16'h9234, 8'h00); drain(1'b0);
    checkVal("rd9234", 16'(rspRdata), 16'h00C3);
    issue(1'b0, 16'hFFFF, 8'h00); drain(1'b1);
    checkVal("rdFFFF", 16'(rspRdata), 16'h0022);
    issue(1'b1, 16'h1000, 8'hFF); drain(1'b0);

    // Reset in the second strobe cycle of a write
    issue(1'b1, 16'h9456, 8'h77);
    resetAtPhase(3);
    stepCycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkVal("rstAddr", addr, 16'h0000);

    // Back-to-back alternating write/read with REQ_VALID held high
    for (int i = 0; i < 8; i++) begin
      issue(i[0] ? 1'b0 : 1'b1, 16'h8100 + 16'(i / 2), 8'(8'h30 + i));
    end
    drain(1'b0);

    // Random traffic with idle gaps, noisy inputs while busy and occasional resets
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 7)];
      repeat ($urandom_range(0, 2)) stepCycle(1'b0, 1'($urandom), 16'($urandom), 8'($urandom), 1'b0);
      issue(1'($urandom), a, 8'($urandom));
      if ($urandom_range(0, 9) == 0) resetAtPhase($urandom_range(1, WS + 2));
      else if ($urandom_range(0, 1) == 1) drain(1'b1);
    end
    drain(1'b0);
    stepCycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
